// File: rtl/spi_ram_pkg.sv
// Shared widths for the SPI RAM interface and the register bank behind it.
package spi_ram_pkg;

    localparam int unsigned RAM_ADDR_W = 5;
    localparam int unsigned RAM_DATA_W = 32;
    localparam int unsigned WR_CNT_W   = 8;

    typedef logic [WR_CNT_W-1:0] wr_cnt_t;

endpackage : spi_ram_pkg

// File: rtl/spi_write_detect.sv
// Turns the SPI write-enable level into one commit strobe per new write:
// rising edge of the level, or a new address/data pair while the level is held.
module spi_write_detect #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_commit_c
);

    logic              r_we_prev;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              w_changed;

    always_comb begin
        w_changed  = (i_addr != r_addr) || (i_data != r_data);
        o_commit_c = i_we && !i_rst && (!r_we_prev || w_changed);
    end

    // Shadow of the last committed pair; a held level only re-commits on change.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_we_prev <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
        end else begin
            r_we_prev <= i_we;
            if (o_commit_c) begin
                r_addr <= i_addr;
                r_data <= i_data;
            end
        end
    end

endmodule : spi_write_detect

// File: rtl/spi_ram_bank.sv
// Flop-based word RAM shared by the SPI interface (priority) and a user port,
// with a wrapping count of committed writes.
module spi_ram_bank
    import spi_ram_pkg::*;
#(
    parameter int unsigned ADDR_W = RAM_ADDR_W,
    parameter int unsigned DATA_W = RAM_DATA_W
) (
`ifdef USE_POWER_PINS
    inout  wire                vdd,
    inout  wire                vss,
`endif
    input  logic               sys_clock_i,
    input  logic               rst_i,
    input  logic               spi_we_i,
    input  logic [ADDR_W-1:0]  spi_addr_i,
    input  logic [DATA_W-1:0]  spi_data_i,
    output logic [DATA_W-1:0]  spi_data_o,
    input  logic               usr_req_i,
    input  logic               usr_we_i,
    input  logic [ADDR_W-1:0]  usr_addr_i,
    input  logic [DATA_W-1:0]  usr_wdata_i,
    output logic               usr_gnt_o,
    output logic               usr_rvalid_o,
    output logic [DATA_W-1:0]  usr_rdata_o,
    output logic [WR_CNT_W-1:0] wr_count_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_spi_q;
    logic              r_rvalid;
    logic [DATA_W-1:0] r_usr_rdata;
    wr_cnt_t           r_wr_count;

    logic w_commit;
    logic w_gnt;
    logic w_usr_wr;
    logic w_usr_rd;

    spi_write_detect #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_detect (
        .i_clk      (sys_clock_i),
        .i_rst      (rst_i),
        .i_we       (spi_we_i),
        .i_addr     (spi_addr_i),
        .i_data     (spi_data_i),
        .o_commit_c (w_commit)
    );

    // SPI commit always wins; the user port waits out any commit cycle.
    always_comb begin
        w_gnt    = !rst_i && !w_commit;
        w_usr_wr = usr_req_i && w_gnt && usr_we_i;
        w_usr_rd = usr_req_i && w_gnt && !usr_we_i;
    end

    always_ff @(posedge sys_clock_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_commit) begin
            r_mem[spi_addr_i] <= spi_data_i;
        end else if (w_usr_wr) begin
            r_mem[usr_addr_i] <= usr_wdata_i;
        end
    end

    // Read ports sample the array before this edge's write, giving old data on collision.
    always_ff @(posedge sys_clock_i) begin
        if (rst_i) begin
            r_spi_q     <= '0;
            r_rvalid    <= 1'b0;
            r_usr_rdata <= '0;
            r_wr_count  <= '0;
        end else begin
            r_spi_q  <= r_mem[spi_addr_i];
            r_rvalid <= w_usr_rd;
            if (w_usr_rd) begin
                r_usr_rdata <= r_mem[usr_addr_i];
            end
            if (w_commit || w_usr_wr) begin
                r_wr_count <= r_wr_count + WR_CNT_W'(1);
            end
        end
    end

    assign spi_data_o   = r_spi_q;
    assign usr_gnt_o    = w_gnt;
    assign usr_rvalid_o = r_rvalid;
    assign usr_rdata_o  = r_usr_rdata;
    assign wr_count_o   = r_wr_count;

endmodule : spi_ram_bank

// File: tb/tb_spi_ram_bank.sv
// Bench for spi_ram_bank: directed scenarios plus random traffic against an array model.
module tb_spi_ram_bank;

    logic        clk;
    logic        rst;
    logic        spi_we;
    logic [4:0]  spi_addr;
    logic [31:0] spi_data;
    logic [31:0] spi_q;
    logic        usr_req;
    logic        usr_we;
    logic [4:0]  usr_addr;
    logic [31:0] usr_wdata;
    logic        usr_gnt;
    logic        usr_rvalid;
    logic [31:0] usr_rdata;
    logic [7:0]  wr_count;

    int n_checks = 0;
    int n_fail   = 0;

    spi_ram_bank dut (
        .sys_clock_i  (clk),
        .rst_i        (rst),
        .spi_we_i     (spi_we),
        .spi_addr_i   (spi_addr),
        .spi_data_i   (spi_data),
        .spi_data_o   (spi_q),
        .usr_req_i    (usr_req),
        .usr_we_i     (usr_we),
        .usr_addr_i   (usr_addr),
        .usr_wdata_i  (usr_wdata),
        .usr_gnt_o    (usr_gnt),
        .usr_rvalid_o (usr_rvalid),
        .usr_rdata_o  (usr_rdata),
        .wr_count_o   (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    // Reference model: plain array plus last committed pair
    logic [31:0] m_mem [32];
    bit          m_prev;
    logic [4:0]  m_la;
    logic [31:0] m_ld;
    logic [31:0] m_q;
    logic [31:0] m_rdata;
    bit          m_rv;
    int          m_cnt;
    bit          model_on = 0;
    bit          m_c;

    function automatic bit commit_pred();
        return spi_we && (!m_prev || spi_addr != m_la || spi_data != m_ld);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) m_mem[i] = '0;
            m_la = '0; m_ld = '0; m_q = '0; m_rdata = '0; m_rv = 0; m_cnt = 0;
            m_prev = 0;
        end else begin
            m_c  = commit_pred();
            m_q  = m_mem[spi_addr];
            m_rv = 0;
            if (!m_c && usr_req && !usr_we) begin
                m_rv    = 1;
                m_rdata = m_mem[usr_addr];
            end
            if (m_c) begin
                m_mem[spi_addr] = spi_data;
                m_la  = spi_addr;
                m_ld  = spi_data;
                m_cnt = (m_cnt + 1) % 256;
            end else if (usr_req && usr_we) begin
                m_mem[usr_addr] = usr_wdata;
                m_cnt = (m_cnt + 1) % 256;
            end
            m_prev = spi_we;
        end
        model_on = 1;
    end

    // Registered outputs against the model, every cycle
    always @(negedge clk) begin
        if (model_on) begin
            chk("spi_data_o", spi_q, m_q);
            chk("usr_rvalid_o", 32'(usr_rvalid), 32'(m_rv));
            chk("usr_rdata_o", usr_rdata, m_rdata);
            chk("wr_count_o", 32'(wr_count), 32'(m_cnt));
        end
    end

    // Combinational grant, once inputs have settled for the cycle
    always @(negedge clk) begin
        #3;
        if (model_on) chk("usr_gnt_o", 32'(usr_gnt), 32'(!rst && !commit_pred()));
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1; spi_we = 0; spi_addr = '0; spi_data = '0;
        usr_req = 0; usr_we = 0; usr_addr = '0; usr_wdata = '0;
        repeat (3) tick();
        chk("reset_count", 32'(wr_count), 32'd0);
        chk("reset_gnt", 32'(usr_gnt), 32'd0);
        rst = 0;

        // All words read zero after reset
        for (int a = 0; a < 32; a++) begin
            spi_addr = 5'(a);
            tick();
            chk("reset_mem", spi_q, 32'h0);
        end
        chk("count_after_reads", 32'(wr_count), 32'd0);

        // Held level commits once
        spi_we = 1; spi_addr = 5'd3; spi_data = 32'hDEADBEEF;
        repeat (10) tick();
        chk("hold_count", 32'(wr_count), 32'd1);
        chk("hold_read", spi_q, 32'hDEADBEEF);

        // New data under the held level commits again
        spi_data = 32'h12345678;
        #1 chk("change_gnt", 32'(usr_gnt), 32'd0);
        tick();
        chk("change_count", 32'(wr_count), 32'd2);
        chk("change_old_data", spi_q, 32'hDEADBEEF);
        spi_we = 0;
        tick();
        chk("change_read", spi_q, 32'h12345678);

        // Collision on address 7
        spi_we = 1; spi_addr = 5'd7; spi_data = 32'hAAAA5555;
        usr_req = 1; usr_we = 1; usr_addr = 5'd7; usr_wdata = 32'h0BADF00D;
        #1 chk("coll_gnt0", 32'(usr_gnt), 32'd0);
        tick();
        #1 chk("coll_gnt1", 32'(usr_gnt), 32'd1);
        tick();
        chk("coll_spi_stored", spi_q, 32'hAAAA5555);
        usr_req = 0; spi_we = 0;
        tick();
        chk("coll_final", spi_q, 32'h0BADF00D);
        chk("coll_count", 32'(wr_count), 32'd4);

        // User read of address 3
        usr_req = 1; usr_we = 0; usr_addr = 5'd3;
        #1 chk("uread_gnt", 32'(usr_gnt), 32'd1);
        tick();
        chk("uread_valid", 32'(usr_rvalid), 32'd1);
        chk("uread_data", usr_rdata, 32'h12345678);
        usr_req = 0;
        tick();
        chk("uread_pulse_end", 32'(usr_rvalid), 32'd0);
        chk("uread_hold", usr_rdata, 32'h12345678);

        // Access during reset is dropped; a level high at release commits
        rst = 1; usr_req = 1; usr_we = 0;
        spi_we = 1; spi_addr = 5'd5; spi_data = 32'hCAFE0005;
        #1 chk("rst_gnt", 32'(usr_gnt), 32'd0);
        tick();
        chk("rst_no_rvalid", 32'(usr_rvalid), 32'd0);
        chk("rst_count", 32'(wr_count), 32'd0);
        usr_req = 0;
        tick();
        rst = 0;
        tick();
        chk("release_commit", 32'(wr_count), 32'd1);
        tick();
        chk("release_read", spi_q, 32'hCAFE0005);
        spi_we = 0;

        // Counter wrap
        rst = 1;
        tick();
        rst = 0;
        for (int i = 0; i < 256; i++) begin
            usr_req = 1; usr_we = 1; usr_addr = 5'(i); usr_wdata = $urandom;
            tick();
            if (i == 254) chk("wrap_255", 32'(wr_count), 32'd255);
        end
        usr_req = 0;
        chk("wrap_zero", 32'(wr_count), 32'd0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 3) == 0) spi_we = !spi_we;
            if ($urandom_range(0, 2) == 0)
                spi_addr = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            if ($urandom_range(0, 2) == 0) spi_data = $urandom;
            usr_req   = $urandom_range(0, 1) == 1;
            usr_we    = $urandom_range(0, 1) == 1;
            usr_addr  = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            usr_wdata = $urandom;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_spi_ram_bank

// File: doc/spi_ram_bank.md
SPI_RAM_BANK -- requirements
Module: spi_ram_bank

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 5, word-address width; DATA_W, default 32, word width; DEPTH = 2**ADDR_W, derived, entry count.
REQ-002 `sys_clock_i`  in  1  single system clock; every flop is updated on its rising edge.
REQ-003 `rst_i`  in  1  synchronous, active-high reset.
REQ-004 `vdd`, `vss`  inout  1  supply pins; present only under `USE_POWER_PINS`.
REQ-005 `spi_we_i`  in  1  write-enable level from the upstream SPI RAM interface.
REQ-006 `spi_addr_i`  in  ADDR_W  SPI word address.
REQ-007 `spi_data_i`  in  DATA_W  SPI write data.
REQ-008 `spi_data_o`  out  DATA_W  registered read data returned to the SPI interface.
REQ-009 `usr_req_i`  in  1  user-port request, held until granted.
REQ-010 `usr_we_i`  in  1  user-port operation: 1 = write, 0 = read.
REQ-011 `usr_addr_i`  in  ADDR_W  user-port address.
REQ-012 `usr_wdata_i`  in  DATA_W  user-port write data.
REQ-013 `usr_gnt_o`  out  1  combinational grant; the request is accepted in any cycle where `usr_req_i` and `usr_gnt_o` are both 1.
REQ-014 `usr_rvalid_o`  out  1  one-cycle pulse; user read data is valid.
REQ-015 `usr_rdata_o`  out  DATA_W  user read data; holds its value between pulses.
REQ-016 `wr_count_o`  out  8  count of committed writes from both ports; wraps from 255 to 0.

Function
REQ-017 Storage SHALL be DEPTH x DATA_W flops.
REQ-018 An SPI write commit SHALL occur in a cycle when `spi_we_i`=1 and either condition holds:
- `spi_we_i` was 0 in the previous cycle; or
- {`spi_addr_i`, `spi_data_i`} differs from the last committed SPI pair.
A level held with no change SHALL NOT re-commit.
REQ-019 On an SPI commit, the new value SHALL be readable on the following cycle. The committed pair SHALL be stored in shadow registers for the comparison in REQ-018.
REQ-020 `spi_data_o` SHALL equal mem[`spi_addr_i`] registered, one-cycle latency, every cycle regardless of `spi_we_i`.
REQ-021 Arbitration: an SPI commit SHALL have priority. `usr_gnt_o` SHALL be 0 in any cycle with an SPI commit and SHALL otherwise be 1 (reset excepted).
REQ-022 A granted user write SHALL update mem[`usr_addr_i`] at that clock edge.
REQ-023 A granted user read SHALL produce `usr_rvalid_o`=1 on the next cycle, with `usr_rdata_o` = the memory contents as of the grant edge.
REQ-024 Same-address read-during-write on the SPI read path SHALL return the old data in the commit cycle and the new data one cycle later.
REQ-025 `wr_count_o` SHALL increment by 1 per SPI commit or granted user write. At most one increment per cycle is possible because of REQ-021.
REQ-026 Addresses are exactly ADDR_W wide; out-of-range addresses are not possible, and no wrap logic is required.
REQ-027 If `usr_req_i` drops before a grant, nothing SHALL happen and no error SHALL be flagged.

Reset
REQ-028 While `rst_i`=1 the following SHALL be 0: all memory words, `spi_data_o`, `usr_rdata_o`, `usr_rvalid_o`, `wr_count_o`, the SPI shadow registers, and the previous-`spi_we_i` flop.
REQ-029 `usr_gnt_o` SHALL be 0 while `rst_i`=1.
REQ-030 An SPI commit or user access in a reset cycle SHALL be discarded.
REQ-031 A read in flight when reset asserts SHALL NOT produce an `usr_rvalid_o` pulse.
REQ-032 After reset deasserts, a `spi_we_i` level already high SHALL count as a rising edge and commit.

Structure
REQ-033 ADDR_W, DATA_W, and the counter width SHALL be defined in shared package `spi_ram_pkg`, which is also used by the SPI interface top.
REQ-034 The SPI commit detector (edge/change detect plus shadow registers) SHALL be a sub-module `spi_write_detect` that outputs a one-cycle commit strobe.
REQ-035 spi_ram_bank SHALL connect directly to the SPI interface signals `we_o`/`addr_o`/`data_o`/`data_i` with no glue logic.

Verification
REQ-036 Reset release: read all 32 addresses via the SPI path -> each returns 0x00000000; `wr_count_o`=0.
REQ-037 Level-hold write: `spi_we_i`=1, addr 3, data 0xDEADBEEF held 10 cycles -> one commit; `wr_count_o`=1; addr 3 reads 0xDEADBEEF.
REQ-038 Changing data under a held level: data changes to 0x12345678 while `spi_we_i` stays 1 -> second commit; `wr_count_o`=2.
REQ-039 Collision: SPI commit to addr 7 and user write to addr 7 in the same cycle -> `usr_gnt_o`=0; SPI data is stored; the user write lands the next cycle and the final value is the user data.
REQ-040 User read of addr 3 -> `usr_rvalid_o` pulses one cycle later with 0x12345678.
REQ-041 Counter wrap: 256 granted user writes -> `wr_count_o` returns to 0.
